// File: rtl/stream_mux_if.sv
// stream_mux_if: bundled input channels and output stream of the stream multiplexer.
interface stream_mux_if #(
   parameter int N_SEL = 2,
   parameter int WIDTH = 8
);
   localparam int N = 2 ** N_SEL;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [N_SEL-1:0]   out_ch;
   logic               out_valid;
   logic               out_ready;
   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_last, out_ch, out_valid
   );
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_last, out_ch, out_valid
   );
endinterface

// File: rtl/stream_mux.sv
// stream_mux: registered multi-channel stream merge with packet-locked round-robin grant.
module stream_mux #(
   parameter int N_SEL = 2,
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst,
   stream_mux_if.slave bus
);
   localparam int N = 2 ** N_SEL;
   typedef enum logic {IDLE, LOCK} state_t;
   state_t           state, state_nx;
   logic [N_SEL-1:0] ptr, grant, pick, idx;
   logic             found, room, load, done;
   // scan downward so the nearest valid channel at or after ptr wins
   always_comb begin
      pick  = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int i = N - 1; i >= 0; i--) begin
         idx = ptr + N_SEL'(i);
         if (bus.in_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
   assign room         = !bus.out_valid || bus.out_ready;
   assign load         = state == LOCK && bus.in_valid[grant] && room;
   assign done         = load && bus.in_last[grant];
   assign bus.in_ready = (state == LOCK && room) ? N'(1) << grant : '0;
   always_comb state_nx = state == IDLE ? (found ? LOCK : IDLE) : (done ? IDLE : LOCK);
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         grant         <= '0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_ch    <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && found) grant <= pick;
         if (done) ptr <= grant + N_SEL'(1);
         if (load) begin
            bus.out_data  <= bus.in_data[grant*WIDTH +: WIDTH];
            bus.out_last  <= bus.in_last[grant];
            bus.out_ch    <= grant;
            bus.out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed stimulus into per-channel sources, scoreboard monitor on the output.
module tb_stream_mux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_mux_if #(.N_SEL(2), .WIDTH(8)) bus();
   stream_mux #(.N_SEL(2), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int         gap;
      logic [1:0] ch;
      logic       last;
      logic [7:0] data;
   } exp_t;

   exp_t       expq[$];
   logic [9:0] srcq[4][$];
   logic [3:0] drove_bub;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send(input int ch, input logic [7:0] d, input logic last, input int gap);
      exp_t e;
      srcq[ch].push_back({1'b0, last, d});
      e.gap = gap; e.ch = 2'(ch); e.last = last; e.data = d;
      expq.push_back(e);
   endtask

   task automatic src_only(input int ch, input logic [7:0] d, input logic last);
      srcq[ch].push_back({1'b0, last, d});
   endtask

   task automatic bubble(input int ch);
      srcq[ch].push_back(10'h200);
   endtask

   task automatic wait_drain(input int n);
      int i = 0;
      while (expq.size() != 0 && i < n) begin
         @(negedge clk);
         i++;
      end
      if (expq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", expq.size());
         expq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid(input int n);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!bus.out_valid && i < n);
      chk("wait_out_valid", 32'(bus.out_valid), 32'd1);
   endtask

   // source model: holds each head word until the DUT accepts it; bubbles last one cycle
   initial begin
      logic [3:0] acc;
      logic       rs;
      bus.in_valid = '0;
      bus.in_last  = '0;
      bus.in_data  = '0;
      drove_bub    = '0;
      forever begin
         @(negedge clk);
         acc = bus.in_valid & bus.in_ready;
         rs  = rst;
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            if (srcq[k].size() > 0 && (drove_bub[k] || (!rs && acc[k]))) void'(srcq[k].pop_front());
            if (srcq[k].size() > 0) begin
               drove_bub[k]          = srcq[k][0][9];
               bus.in_valid[k]       = !srcq[k][0][9];
               bus.in_last[k]        = srcq[k][0][8];
               bus.in_data[k*8 +: 8] = srcq[k][0][7:0];
            end else begin
               drove_bub[k]    = 1'b0;
               bus.in_valid[k] = 1'b0;
               bus.in_last[k]  = 1'b0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: ch=%0d data=%h, required no word", bus.out_ch, bus.out_data);
            end else begin
               e = expq.pop_front();
               chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
               chk("out_data", 32'(bus.out_data), 32'(e.data));
               chk("out_last", 32'(bus.out_last), 32'(e.last));
               if (e.gap != 0) chk("word_spacing", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.out_ready = 1'b1;
      // round-robin stimulus offered during reset; nothing may move until release
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 4; k++)
            send(k, 8'h10 + 8'(k), 1'b1, (r == 0 && k == 0) ? 0 : 2);
      repeat (2) begin
         @(negedge clk);
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_out_data", 32'(bus.out_data), 32'd0);
         chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
         chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      wait_drain(200);

      // packet lock: ch1 packet contiguous, ch2 waits for it
      send(1, 8'hA1, 1'b0, 0);
      send(1, 8'hA2, 1'b0, 1);
      send(1, 8'hA3, 1'b1, 1);
      send(2, 8'hB0, 1'b1, 2);
      wait_drain(200);

      // backpressure mid-packet on ch3
      send(3, 8'h30, 1'b0, 0);
      send(3, 8'h31, 1'b0, 6);
      send(3, 8'h32, 1'b0, 1);
      send(3, 8'h33, 1'b1, 1);
      wait_valid(50);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_out_data", 32'(bus.out_data), 32'h31);
         chk("stall_out_ch", 32'(bus.out_ch), 32'd3);
         chk("stall_out_last", 32'(bus.out_last), 32'd0);
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      wait_drain(200);

      // pointer wrapped to 0: ch0 beats ch3; ch0 gap keeps the grant
      send(0, 8'h40, 1'b0, 0);
      repeat (4) bubble(0);
      send(0, 8'h41, 1'b0, 5);
      send(0, 8'h42, 1'b1, 1);
      send(3, 8'h3F, 1'b1, 2);
      wait_valid(50);
      repeat (3) begin
         @(negedge clk);
         chk("gap_in_ready", 32'(bus.in_ready), 32'h1);
      end
      wait_drain(200);

      // move ptr to 2, then reset with a word stuck in the output register
      send(1, 8'h5F, 1'b1, 0);
      wait_drain(200);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      src_only(2, 8'h50, 1'b0);
      src_only(2, 8'h51, 1'b0);
      src_only(2, 8'h52, 1'b1);
      wait_valid(50);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) srcq[k].delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_out_ch", 32'(bus.out_ch), 32'd0);
      send(1, 8'h61, 1'b1, 0);
      send(2, 8'h62, 1'b1, 2);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      wait_drain(200);
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(expq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
